// File: rtl/jpeg_pkg.sv
// Shared JPEG scan constants and the bit-window destuffer state type.
package jpeg_pkg;

    localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;
    localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
    localparam logic [7:0] JPEG_RST_FIRST     = 8'hD0;
    localparam logic [7:0] JPEG_RST_LAST      = 8'hD7;
    localparam logic [7:0] JPEG_EOI           = 8'hD9;

    typedef enum logic [1:0] {
        StNormal,
        StPendFf,
        StHalt
    } bitwin_state_t;

    function automatic logic is_rst_marker(input logic [7:0] code);
        return (code >= JPEG_RST_FIRST) && (code <= JPEG_RST_LAST);
    endfunction

endpackage

// File: rtl/jpeg_destuff.sv
// Removes 0xFF00 stuffing and halts on the first real marker; emits one append strobe per
// data byte.
module jpeg_destuff
    import jpeg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       accept,
    output logic       append_valid,
    output logic [7:0] append_byte,
    output logic       halt,
    output logic       halt_next,
    output logic       marker_found,
    output logic [7:0] marker_code
);

    bitwin_state_t state_q;
    logic          is_marker;

    always_comb begin
        append_valid = 1'b0;
        append_byte  = byte_in;
        is_marker    = 1'b0;
        if (accept) begin
            unique case (state_q)
                StNormal: append_valid = (byte_in != JPEG_MARKER_PREFIX);
                StPendFf: begin
                    if (byte_in == JPEG_STUFF_BYTE) begin
                        append_valid = 1'b1;
                        append_byte  = JPEG_MARKER_PREFIX;
                    end else if (byte_in != JPEG_MARKER_PREFIX) begin
                        is_marker = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign halt      = (state_q == StHalt);
    assign halt_next = halt || is_marker;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StNormal;
            marker_found <= 1'b0;
            marker_code  <= 8'h00;
        end else if (accept) begin
            unique case (state_q)
                StNormal: if (byte_in == JPEG_MARKER_PREFIX) state_q <= StPendFf;
                StPendFf: begin
                    if (byte_in == JPEG_STUFF_BYTE) begin
                        state_q <= StNormal;
                    end else if (byte_in != JPEG_MARKER_PREFIX) begin
                        state_q      <= StHalt;
                        marker_found <= 1'b1;
                        marker_code  <= byte_in;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/jpeg_bit_window.sv
// Left-aligned bit buffer feeding a 16-bit look-ahead window to the Huffman decoder.
// Optional JPEG_BITWIN_MARKER_PAD_EN: 1-pad the window tail once a marker halts the stream.
module jpeg_bit_window
    import jpeg_pkg::*;
#(
    parameter int unsigned BUF_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        consume,
    input  logic [4:0]  consume_len,
    output logic [15:0] code,
    output logic        code_valid,
    output logic [5:0]  bits_avail,
    output logic        marker_found,
    output logic [7:0]  marker_code,
    output logic        underflow
);

    localparam logic [5:0] FillMax = 6'(BUF_W - 8);

    logic [BUF_W-1:0] buf_q, buf_d, sh_buf;
    logic [5:0]       fill_q, fill_d, sh_fill;
    logic             accept, shift_ok, append_valid, halt, halt_next;
    logic [7:0]       append_byte;
    logic [15:0]      code_d;
    logic             code_valid_d;

    assign byte_ready = !rst && !halt && (fill_q <= FillMax);
    assign accept     = byte_valid && byte_ready;
    assign shift_ok   = consume && ({1'b0, consume_len} <= fill_q);

    jpeg_destuff u_destuff (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .accept       (accept),
        .append_valid (append_valid),
        .append_byte  (append_byte),
        .halt         (halt),
        .halt_next    (halt_next),
        .marker_found (marker_found),
        .marker_code  (marker_code)
    );

    // Shift first, then the new byte lands directly below the surviving bits.
    always_comb begin
        sh_buf  = shift_ok ? (buf_q << consume_len) : buf_q;
        sh_fill = shift_ok ? (fill_q - {1'b0, consume_len}) : fill_q;
        buf_d   = sh_buf;
        fill_d  = sh_fill;
        if (append_valid) begin
            buf_d  = sh_buf | ({append_byte, {(BUF_W-8){1'b0}}} >> sh_fill);
            fill_d = sh_fill + 6'd8;
        end
    end

    always_comb begin
        code_d       = buf_d[BUF_W-1 -: 16];
        code_valid_d = (fill_d >= 6'd16);
`ifdef JPEG_BITWIN_MARKER_PAD_EN
        if (halt_next) begin
            code_d       = code_d | (16'hFFFF >> fill_d);
            code_valid_d = code_valid_d || (fill_d != 6'd0);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q      <= '0;
            fill_q     <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            bits_avail <= '0;
            underflow  <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            code       <= code_d;
            code_valid <= code_valid_d;
            bits_avail <= fill_d;
            underflow  <= consume && !shift_ok;
        end
    end

endmodule

// File: tb/tb_jpeg_bit_window.sv
// Directed bench for jpeg_bit_window: destuffing, marker halt, consume, underflow, reset.
module tb_jpeg_bit_window;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        consume = 1'b0;
    logic [4:0]  consume_len = 5'd0;
    logic [15:0] code;
    logic        code_valid;
    logic [5:0]  bits_avail;
    logic        marker_found;
    logic [7:0]  marker_code;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    jpeg_bit_window #(.BUF_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .consume      (consume),
        .consume_len  (consume_len),
        .code         (code),
        .code_valid   (code_valid),
        .bits_avail   (bits_avail),
        .marker_found (marker_found),
        .marker_code  (marker_code),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        consume    = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
    endtask

    task automatic cons(input logic [4:0] n);
        consume     = 1'b1;
        consume_len = n;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset with a byte presented: it must not be accepted.
        byte_in    = 8'h55;
        byte_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_ready", {31'b0, byte_ready}, 32'd0);
        check("rst_code", {16'b0, code}, 32'h0);
        check("rst_valid", {31'b0, code_valid}, 32'd0);
        check("rst_bits", {26'b0, bits_avail}, 32'd0);
        check("rst_mfound", {31'b0, marker_found}, 32'd0);
        check("rst_mcode", {24'b0, marker_code}, 32'd0);
        check("rst_uflow", {31'b0, underflow}, 32'd0);
        byte_valid = 1'b0;
        rst        = 1'b0;
        tick();
        check("post_rst_bits", {26'b0, bits_avail}, 32'd0);

        // Basic stream and consume.
        push(8'h99);
        push(8'hD0);
        check("basic_code", {16'b0, code}, 32'h99D0);
        check("basic_valid", {31'b0, code_valid}, 32'd1);
        check("basic_bits", {26'b0, bits_avail}, 32'd16);
        cons(5'd2);
        check("c2_code", {16'b0, code}, 32'h6740);
        check("c2_bits", {26'b0, bits_avail}, 32'd14);
        check("c2_valid", {31'b0, code_valid}, 32'd0);

        // Stuffing and fill bytes.
        do_reset();
        push(8'hFF); push(8'h00); push(8'h12); push(8'h34);
        check("stuff_code", {16'b0, code}, 32'hFF12);
        check("stuff_bits", {26'b0, bits_avail}, 32'd24);
        push(8'hFF); push(8'hFF); push(8'h00);
        check("fillff_bits", {26'b0, bits_avail}, 32'd32);
        check("fillff_code", {16'b0, code}, 32'hFF12);
        // Full: no accept even with a same-cycle consume.
        byte_in     = 8'h77;
        byte_valid  = 1'b1;
        consume     = 1'b1;
        consume_len = 5'd8;
        #1;
        check("full_ready", {31'b0, byte_ready}, 32'd0);
        tick();
        check("full_bits", {26'b0, bits_avail}, 32'd24);
        check("full_code", {16'b0, code}, 32'h1234);

        // Marker halt.
        do_reset();
        push(8'h12); push(8'hFF); push(8'hD9);
        check("mk_found", {31'b0, marker_found}, 32'd1);
        check("mk_code8", {24'b0, marker_code}, 32'hD9);
        check("mk_ready", {31'b0, byte_ready}, 32'd0);
        check("mk_bits", {26'b0, bits_avail}, 32'd8);
`ifdef JPEG_BITWIN_MARKER_PAD_EN
        check("mk_code", {16'b0, code}, 32'h12FF);
        check("mk_valid", {31'b0, code_valid}, 32'd1);
`else
        check("mk_code", {16'b0, code}, 32'h1200);
        check("mk_valid", {31'b0, code_valid}, 32'd0);
`endif
        push(8'h55);
        check("mk_noaccept", {26'b0, bits_avail}, 32'd8);
        cons(5'd8);
        check("mk_drain", {26'b0, bits_avail}, 32'd0);

        // Simultaneous accept and consume.
        do_reset();
        push(8'hAB); push(8'hCD);
        byte_in     = 8'hEF;
        byte_valid  = 1'b1;
        consume     = 1'b1;
        consume_len = 5'd4;
        tick();
        check("sim_code", {16'b0, code}, 32'hBCDE);
        check("sim_bits", {26'b0, bits_avail}, 32'd20);

        // Underflow.
        do_reset();
        push(8'h5A);
        cons(5'd9);
        check("uf_pulse", {31'b0, underflow}, 32'd1);
        check("uf_code", {16'b0, code}, 32'h5A00);
        check("uf_bits", {26'b0, bits_avail}, 32'd8);
        tick();
        check("uf_clear", {31'b0, underflow}, 32'd0);

        // Reset mid-stream while a 0xFF is pending.
        do_reset();
        push(8'h11); push(8'h22); push(8'h33);
        cons(5'd4);
        check("mid_code", {16'b0, code}, 32'h1223);
        push(8'hFF);
        check("mid_bits", {26'b0, bits_avail}, 32'd20);
        do_reset();
        check("mid_rst_code", {16'b0, code}, 32'h0);
        check("mid_rst_bits", {26'b0, bits_avail}, 32'd0);
        check("mid_rst_valid", {31'b0, code_valid}, 32'd0);
        push(8'h00);
        check("mid_zero_bits", {26'b0, bits_avail}, 32'd8);
        check("mid_zero_code", {16'b0, code}, 32'h0000);
        push(8'h80);
        check("mid_next_code", {16'b0, code}, 32'h0080);
        check("mid_next_bits", {26'b0, bits_avail}, 32'd16);
        check("mid_next_valid", {31'b0, code_valid}, 32'd1);
        check("mid_mfound", {31'b0, marker_found}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
